// File: rtl/iob2axi_pkg.sv
// Shared definitions for the native-to-AXI4 burst write engine:
// AXI encodings, FSM state type and the 4 KB page helper.
package iob2axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0010;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AW    = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Words of width data_w left before the next 4 KB page boundary.
    // A page-aligned address yields a full page (4096 bytes worth of words).
    function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo,
                                                input int unsigned data_w);
        logic [12:0] bytes_left;
        int unsigned shift;
        shift = 0;
        for (int i = 0; i < 16; i++) begin
            if ((32'd8 << i) == data_w) shift = i;
        end
        bytes_left = 13'd4096 - {1'b0, addr_lo};
        return bytes_left >> shift;
    endfunction

endpackage

// File: rtl/iob2axi_burst_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST) and, when
// IOB2AXI_WR_4K_SPLIT_EN is defined, also limited to the words left before
// the next 4 KB boundary.
module iob2axi_burst_calc
    import iob2axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int XFER_W    = 16,
    parameter int MAX_BURST = 256,
    parameter int BEATS_W   = 9
) (
    input  logic [ADDR_W-1:0]  cur_addr,
    input  logic [XFER_W:0]    remaining,
    output logic [BEATS_W-1:0] beats
);

    // Common compare width large enough for remaining and a full 4 KB page.
    localparam int CW = (XFER_W + 1 > 14) ? XFER_W + 1 : 14;
    localparam logic [CW-1:0] BURST_CAP = CW'(MAX_BURST);

    logic [CW-1:0] rem_ext;
    logic [CW-1:0] lim;
    logic          unused_addr_bits;

    assign rem_ext          = CW'(remaining);
    assign unused_addr_bits = ^cur_addr;

`ifdef IOB2AXI_WR_4K_SPLIT_EN
    logic [CW-1:0] page_words;
    assign page_words = CW'(beats_to_4k(cur_addr[11:0], DATA_W));
`endif

    // Smallest of the active limits.
    always_comb begin
        // NOTE: lim is assigned unconditionally first so the later
        // conditional override cannot infer a latch.
        lim = (rem_ext < BURST_CAP) ? rem_ext : BURST_CAP;
`ifdef IOB2AXI_WR_4K_SPLIT_EN
        if (page_words < lim) lim = page_words;
`endif
    end

    assign beats = BEATS_W'(lim);

endmodule

// File: rtl/iob2axi_wr_burst.sv
// Native-to-AXI4 write engine: splits one transfer of length+1 words into
// INCR bursts of at most MAX_BURST beats, keeps up to MAX_OUTSTANDING write
// responses in flight and reports a sticky per-transfer error bit.
// Optional feature macro: IOB2AXI_WR_4K_SPLIT_EN (bursts never cross 4 KB).
module iob2axi_wr_burst
    import iob2axi_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int AXI_LEN_W       = 8,
    parameter int AXI_ID_W        = 1,
    parameter int MAX_BURST       = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int XFER_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  run,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [XFER_W-1:0]     length,
    output logic                  ready,
    output logic                  error,

    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_ready,

    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [AXI_LEN_W-1:0]  m_axi_awlen,
    output logic [AXI_ID_W-1:0]   m_axi_awid,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,

    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,

    input  logic                  m_axi_bvalid,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bready
);

    localparam int OFF_W   = $clog2(DATA_W / 8);
    localparam int BEATS_W = $clog2(MAX_BURST) + 1;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int REM_W   = XFER_W + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

    state_t               state;
    logic [ADDR_W-1:0]    cur_addr;
    logic [REM_W-1:0]     remaining;
    logic [BEATS_W-1:0]   beats_r;
    logic [BEATS_W-1:0]   beat_cnt;
    logic [OUT_W-1:0]     outstanding;
    logic [OUT_W-1:0]     out_next;

    logic [ADDR_W-1:0]    calc_addr;
    logic [REM_W-1:0]     calc_rem;
    logic [BEATS_W-1:0]   calc_beats;

    logic in_data;
    logic aw_hs;
    logic w_hs;
    logic last_beat;
    logic b_dec;
    logic credit_ok;

    // Constant AXI attributes.
    assign m_axi_awid    = '0;
    assign m_axi_awsize  = 3'(OFF_W);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_BUF;
    assign m_axi_awprot  = AXI_PROT_DATA;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_bready  = 1'b1;

    // Data channel is a zero-latency pass-through gated by the DATA state.
    assign in_data      = (state == ST_DATA);
    assign last_beat    = (beat_cnt == beats_r - BEATS_W'(1));
    assign m_axi_wvalid = in_data & s_valid;
    assign s_ready      = in_data & m_axi_wready;
    assign m_axi_wdata  = s_wdata;
    assign m_axi_wstrb  = s_wstrb;
    assign m_axi_wlast  = in_data & last_beat;
    assign ready        = (state == ST_IDLE);

    assign aw_hs     = m_axi_awvalid & m_axi_awready;
    assign w_hs      = in_data & s_valid & m_axi_wready;
    // A response with nothing outstanding is illegal; never let the count wrap.
    assign b_dec     = m_axi_bvalid & (outstanding != '0);
    assign credit_ok = (outstanding < OUT_MAX);

    // Next response-credit count: an AW and a B in the same cycle cancel.
    always_comb begin
        out_next = outstanding;
        if (aw_hs && !b_dec)      out_next = outstanding + OUT_W'(1);
        else if (!aw_hs && b_dec) out_next = outstanding - OUT_W'(1);
    end

    // In IDLE the first burst is sized straight from the request so awvalid
    // can rise the cycle after run; afterwards from the running counters.
    always_comb begin
        if (state == ST_IDLE) begin
            calc_addr = addr & ALIGN_MASK;
            calc_rem  = REM_W'(length) + REM_W'(1);
        end else begin
            calc_addr = cur_addr;
            calc_rem  = remaining;
        end
    end

    iob2axi_burst_calc #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .XFER_W    (XFER_W),
        .MAX_BURST (MAX_BURST),
        .BEATS_W   (BEATS_W)
    ) u_burst_calc (
        .cur_addr  (calc_addr),
        .remaining (calc_rem),
        .beats     (calc_beats)
    );

    // Transfer FSM with address/length counters, credit count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            beats_r       <= '0;
            beat_cnt      <= '0;
            outstanding   <= '0;
            error         <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            outstanding <= out_next;
            if (m_axi_bvalid && state != ST_IDLE && m_axi_bresp != AXI_RESP_OKAY)
                error <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (run) begin
                        error         <= 1'b0;
                        cur_addr      <= calc_addr;
                        remaining     <= calc_rem;
                        beats_r       <= calc_beats;
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= calc_addr;
                        m_axi_awlen   <= AXI_LEN_W'(calc_beats - BEATS_W'(1));
                        state         <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        cur_addr      <= cur_addr + (ADDR_W'(beats_r) << OFF_W);
                        remaining     <= remaining - REM_W'(beats_r);
                        beat_cnt      <= '0;
                        state         <= ST_DATA;
                    end else if (!m_axi_awvalid && credit_ok) begin
                        beats_r       <= calc_beats;
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= cur_addr;
                        m_axi_awlen   <= AXI_LEN_W'(calc_beats - BEATS_W'(1));
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + BEATS_W'(1);
                        if (last_beat)
                            state <= (remaining != '0) ? ST_AW : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_next == '0) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob2axi_wr_burst.sv
// Directed self-checking bench for iob2axi_wr_burst (MAX_OUTSTANDING=2).
// Expected burst tables follow IOB2AXI_WR_4K_SPLIT_EN when it is defined.
module tb_iob2axi_wr_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] length = '0;
    logic        ready, error;
    logic        s_valid = 1'b1;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = 4'hF;
    logic        s_ready;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b1;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [0:0]  m_axi_awid;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b1;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bready;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    int cyc = 0;
    int w_beats = 0;
    int b_cnt = 0;
    int wdata_bad = 0;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          aw_cyc_q[$];
    int          wlast_q[$];
    int          b_cyc_q[$];

    // Responder controls
    bit b_en = 1'b1;
    int slverr_at = -1;
    int ready_cyc = 0;

    iob2axi_wr_burst #(
        .ADDR_W(32), .DATA_W(32), .AXI_LEN_W(8), .AXI_ID_W(1),
        .MAX_BURST(256), .MAX_OUTSTANDING(2), .XFER_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .run(run), .addr(addr), .length(length), .ready(ready), .error(error),
        .s_valid(s_valid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awid(m_axi_awid),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    // Handshake monitor: logs AW, W and B handshakes seen at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_q.push_back(m_axi_awaddr);
            aw_len_q.push_back(m_axi_awlen);
            aw_cyc_q.push_back(cyc);
        end
        if (m_axi_wvalid && m_axi_wready) begin
            if (m_axi_wdata !== 32'(w_beats)) wdata_bad <= wdata_bad + 1;
            if (m_axi_wlast) wlast_q.push_back(w_beats);
            w_beats <= w_beats + 1;
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_cyc_q.push_back(cyc);
            b_cnt <= b_cnt + 1;
        end
    end

    // Source and B responder: one B per completed burst, one cycle after wlast.
    always @(negedge clk) begin
        s_wdata      <= 32'(w_beats);
        m_axi_bvalid <= b_en && (b_cnt < wlast_q.size());
        m_axi_bresp  <= (b_cnt == slverr_at) ? 2'b10 : 2'b00;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [15:0] len);
        @(negedge clk);
        addr   = a;
        length = len;
        run    = 1'b1;
        @(negedge clk);
        run    = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        ready_cyc = cyc;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: ready=%b after %0d cycles, required 1", name, ready, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b need 1", ready); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b need 0", error); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b need 0", s_ready); end
        n_checks++; if (m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %b need 0", m_axi_awvalid); end
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid: got %b need 0", m_axi_wvalid); end
        n_checks++; if (m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL rst_wlast: got %b need 0", m_axi_wlast); end
        n_checks++; if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL rst_bready: got %b need 1", m_axi_bready); end
        n_checks++;
        if ({m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_awlock, m_axi_awqos} !==
            {3'd2, 2'b01, 4'd2, 3'd2, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_aw_attrs: got size=%0d burst=%0d cache=%0d prot=%0d lock=%0d qos=%0d need 2 1 2 2 0 0",
                     m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_awlock, m_axi_awqos);
        end
    endtask

    // length=0 at unaligned 0x103, awready held low 3 cycles first.
    task automatic test_single();
        int ab = aw_addr_q.size();
        int wb = w_beats;
        int lb = wlast_q.size();
        int bb = b_cnt;
        m_axi_awready = 1'b0;
        start_xfer(32'h103, 16'd0);
        n_checks++; if (m_axi_awvalid !== 1'b1) begin n_fail++; $display("FAIL single_awvalid_c1: got %b need 1", m_axi_awvalid); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_c1: got %b need 0", ready); end
        n_checks++; if (m_axi_awaddr !== 32'h100) begin n_fail++; $display("FAIL single_awaddr: got %0h need 100", m_axi_awaddr); end
        n_checks++; if (m_axi_awlen !== 8'd0) begin n_fail++; $display("FAIL single_awlen: got %0d need 0", m_axi_awlen); end
        repeat (3) @(negedge clk);
        n_checks++; if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h100) begin
            n_fail++; $display("FAIL single_aw_hold: got valid=%b addr=%0h need 1 100", m_axi_awvalid, m_axi_awaddr); end
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL single_wvalid_early: got %b need 0", m_axi_wvalid); end
        m_axi_awready = 1'b1;
        wait_ready("single", 50);
        n_checks++; if (aw_addr_q.size() - ab !== 1) begin n_fail++; $display("FAIL single_aw_count: got %0d need 1", aw_addr_q.size() - ab); end
        n_checks++; if (w_beats - wb !== 1) begin n_fail++; $display("FAIL single_beats: got %0d need 1", w_beats - wb); end
        n_checks++; if (wlast_q.size() - lb !== 1 || wlast_q[lb] - wb !== 0) begin
            n_fail++; $display("FAIL single_wlast: got count %0d need 1 at beat 0", wlast_q.size() - lb); end
        n_checks++; if (b_cnt - bb !== 1) begin n_fail++; $display("FAIL single_b_count: got %0d need 1", b_cnt - bb); end
        n_checks++; if (ready_cyc !== b_cyc_q[b_cyc_q.size()-1] + 1) begin
            n_fail++; $display("FAIL single_ready_latency: ready at %0d, B at %0d, need B+1", ready_cyc, b_cyc_q[b_cyc_q.size()-1]); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b need 0", error); end
    endtask

    // length=599 from 0: bursts of 256, 256, 88. A stray run mid-transfer is ignored.
    task automatic test_multi();
        logic [31:0] exp_addr[3] = '{32'h0, 32'h400, 32'h800};
        logic [7:0]  exp_len[3]  = '{8'd255, 8'd255, 8'd87};
        int          exp_last[3] = '{255, 511, 599};
        int ab = aw_addr_q.size();
        int wb = w_beats;
        int lb = wlast_q.size();
        int bb = b_cnt;
        start_xfer(32'h0, 16'd599);
        repeat (10) @(negedge clk);
        addr = 32'h5000; length = 16'd7; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_ready("multi", 2000);
        n_checks++; if (aw_addr_q.size() - ab !== 3) begin n_fail++; $display("FAIL multi_aw_count: got %0d need 3", aw_addr_q.size() - ab); end
        for (int i = 0; i < 3; i++) begin
            if (ab + i < aw_addr_q.size()) begin
                n_checks++; if (aw_addr_q[ab+i] !== exp_addr[i] || aw_len_q[ab+i] !== exp_len[i]) begin
                    n_fail++; $display("FAIL multi_aw%0d: got addr=%0h len=%0d need %0h %0d",
                                       i, aw_addr_q[ab+i], aw_len_q[ab+i], exp_addr[i], exp_len[i]); end
            end
            if (lb + i < wlast_q.size()) begin
                n_checks++; if (wlast_q[lb+i] - wb !== exp_last[i]) begin
                    n_fail++; $display("FAIL multi_wlast%0d: got beat %0d need %0d", i, wlast_q[lb+i] - wb, exp_last[i]); end
            end
        end
        n_checks++; if (wlast_q.size() - lb !== 3) begin n_fail++; $display("FAIL multi_wlast_count: got %0d need 3", wlast_q.size() - lb); end
        n_checks++; if (w_beats - wb !== 600) begin n_fail++; $display("FAIL multi_beats: got %0d need 600", w_beats - wb); end
        n_checks++; if (b_cnt - bb !== 3) begin n_fail++; $display("FAIL multi_b_count: got %0d need 3", b_cnt - bb); end
        n_checks++; if (wdata_bad !== 0) begin n_fail++; $display("FAIL multi_wdata: got %0d bad beats need 0", wdata_bad); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL multi_error: got %b need 0", error); end
    endtask

    // 4 words starting 8 bytes before a 4 KB page.
    task automatic test_4k();
`ifdef IOB2AXI_WR_4K_SPLIT_EN
        int          n_exp = 2;
        logic [31:0] exp_addr[2] = '{32'hFF8, 32'h1000};
        logic [7:0]  exp_len[2]  = '{8'd1, 8'd1};
`else
        int          n_exp = 1;
        logic [31:0] exp_addr[1] = '{32'hFF8};
        logic [7:0]  exp_len[1]  = '{8'd3};
`endif
        int ab = aw_addr_q.size();
        int wb = w_beats;
        start_xfer(32'hFF8, 16'd3);
        wait_ready("page", 100);
        n_checks++; if (aw_addr_q.size() - ab !== n_exp) begin
            n_fail++; $display("FAIL page_aw_count: got %0d need %0d", aw_addr_q.size() - ab, n_exp); end
        for (int i = 0; i < n_exp; i++) begin
            if (ab + i < aw_addr_q.size()) begin
                n_checks++; if (aw_addr_q[ab+i] !== exp_addr[i] || aw_len_q[ab+i] !== exp_len[i]) begin
                    n_fail++; $display("FAIL page_aw%0d: got addr=%0h len=%0d need %0h %0d",
                                       i, aw_addr_q[ab+i], aw_len_q[ab+i], exp_addr[i], exp_len[i]); end
            end
        end
        n_checks++; if (w_beats - wb !== 4) begin n_fail++; $display("FAIL page_beats: got %0d need 4", w_beats - wb); end
    endtask

    // Credit limit 2: third AW waits for the first B.
    task automatic test_credit();
        int ab = aw_addr_q.size();
        int wb = w_beats;
        int bb = b_cnt;
        b_en = 1'b0;
        start_xfer(32'h0, 16'd767);
        repeat (700) @(negedge clk);
        n_checks++; if (aw_addr_q.size() - ab !== 2) begin n_fail++; $display("FAIL credit_aw_blocked: got %0d AWs need 2", aw_addr_q.size() - ab); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL credit_ready_blocked: got %b need 0", ready); end
        b_en = 1'b1;
        wait_ready("credit", 2000);
        n_checks++; if (aw_addr_q.size() - ab !== 3) begin n_fail++; $display("FAIL credit_aw_count: got %0d need 3", aw_addr_q.size() - ab); end
        if (aw_addr_q.size() - ab >= 3 && b_cnt - bb >= 1) begin
            n_checks++; if (aw_cyc_q[ab+2] <= b_cyc_q[bb]) begin
                n_fail++; $display("FAIL credit_aw3_order: AW3 at %0d, first B at %0d, need AW3 later", aw_cyc_q[ab+2], b_cyc_q[bb]); end
        end
        n_checks++; if (b_cnt - bb !== 3) begin n_fail++; $display("FAIL credit_b_count: got %0d need 3", b_cnt - bb); end
        n_checks++; if (w_beats - wb !== 768) begin n_fail++; $display("FAIL credit_beats: got %0d need 768", w_beats - wb); end
    endtask

    // SLVERR on the second burst; next run clears the flag.
    task automatic test_error();
        slverr_at = b_cnt + 1;
        start_xfer(32'h0, 16'd599);
        wait_ready("err", 2000);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b need 1", error); end
        slverr_at = -1;
        start_xfer(32'h2000, 16'd0);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_run: got %b need 0", error); end
        wait_ready("err2", 50);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clean_xfer: got %b need 0", error); end
    endtask

    // Reset during beat 5 aborts immediately; a fresh run then completes.
    task automatic test_reset_mid();
        int wb = w_beats;
        int ab, lb, bb;
        int n = 0;
        start_xfer(32'h300, 16'd15);
        while (w_beats - wb < 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (m_axi_wvalid !== 1'b1 || w_beats - wb !== 4) begin
            n_fail++; $display("FAIL mid_beat5: got wvalid=%b beats=%0d need 1 4", m_axi_wvalid, w_beats - wb); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready, error, m_axi_awvalid, m_axi_wvalid, s_ready, m_axi_wlast, m_axi_bready} !== 7'b1000001) begin
            n_fail++; $display("FAIL mid_reset_outputs: got rdy,err,awv,wv,srdy,wlast,brdy=%b need 1000001",
                               {ready, error, m_axi_awvalid, m_axi_wvalid, s_ready, m_axi_wlast, m_axi_bready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ab = aw_addr_q.size();
        lb = wlast_q.size();
        bb = b_cnt;
        wb = w_beats;
        start_xfer(32'h200, 16'd3);
        wait_ready("mid_fresh", 100);
        n_checks++; if (aw_addr_q.size() - ab !== 1) begin n_fail++; $display("FAIL mid_fresh_aw_count: got %0d need 1", aw_addr_q.size() - ab); end
        if (aw_addr_q.size() > ab) begin
            n_checks++; if (aw_addr_q[ab] !== 32'h200 || aw_len_q[ab] !== 8'd3) begin
                n_fail++; $display("FAIL mid_fresh_aw: got addr=%0h len=%0d need 200 3", aw_addr_q[ab], aw_len_q[ab]); end
        end
        n_checks++; if (w_beats - wb !== 4 || wlast_q.size() - lb !== 1) begin
            n_fail++; $display("FAIL mid_fresh_data: got beats=%0d wlasts=%0d need 4 1", w_beats - wb, wlast_q.size() - lb); end
        n_checks++; if (b_cnt - bb !== 1) begin n_fail++; $display("FAIL mid_fresh_b: got %0d need 1", b_cnt - bb); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_4k();
        test_credit();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
